// File: rtl/peripheral_native_arbiter_pkg.sv
// rtl/peripheral_native_arbiter_pkg.sv - shared types and register map for the native register arbiter
package peripheral_native_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_COUNT  = 2'd0;
  localparam logic [1:0] ADDR_CONFIG = 2'd1;
  localparam logic [1:0] ADDR_FIFO   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CFG_EN_BIT   = 0;
  localparam int CFG_DIR_BIT  = 1;
  localparam int CFG_IRE_BIT  = 2;
  localparam int CFG_LT1K_BIT = 3;

  localparam int STAT_EMPTY_BIT  = 0;
  localparam int STAT_FULL_BIT   = 1;
  localparam int STAT_WCOUNT_LSB = 8;

  // CONFIG read-back word
  function automatic logic [31:0] pack_config(input logic en, input logic dir,
                                              input logic ire, input logic lt1k);
    logic [31:0] w;
    w = '0;
    w[CFG_EN_BIT]   = en;
    w[CFG_DIR_BIT]  = dir;
    w[CFG_IRE_BIT]  = ire;
    w[CFG_LT1K_BIT] = lt1k;
    return w;
  endfunction

  // STATUS read-back word
  function automatic logic [31:0] pack_status(input logic [7:0] wcount, input logic full,
                                              input logic empty);
    logic [31:0] w;
    w = '0;
    w[STAT_EMPTY_BIT] = empty;
    w[STAT_FULL_BIT]  = full;
    w[STAT_WCOUNT_LSB +: 8] = wcount;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last grant
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  // Scan requesters from last_grant+1 with wraparound; first active one wins
  always_comb begin
    logic found;
    int   cand;
    found     = 1'b0;
    grant_idx = '0;
    grant     = '0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last_grant) + i) % N;
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = IW'(cand);
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/peripheral_native_register_arbiter.sv
// rtl/peripheral_native_register_arbiter.sv - shares the core's native register port among requesters
module peripheral_native_register_arbiter
  import peripheral_native_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_we,
  input  logic [2*NUM_REQ-1:0]    req_addr,
  input  logic [32*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      ack,
  output logic [31:0]             rdata,
  output logic                    err,
  output logic [31:0]             count_in,
  output logic                    en_in,
  output logic                    dir_in,
  output logic                    ire_in,
  output logic [7:0]              fifo_data_in,
  output logic                    count_we,
  output logic                    config_we,
  output logic                    fifo_we,
  output logic                    fifo_re,
  input  logic [31:0]             count_out,
  input  logic                    en_out,
  input  logic                    dir_out,
  input  logic                    ire_out,
  input  logic                    lt_1k_out,
  input  logic                    fifo_empty,
  input  logic                    fifo_full,
  input  logic [7:0]              fifo_word_count,
  input  logic [7:0]              fifo_data_out
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state_q;
  logic [IW-1:0]        owner_q;
  logic [IW-1:0]        last_grant_q;
  logic                 we_q;
  logic [1:0]           addr_q;
  logic [31:0]          wdata_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic [31:0]          rdata_q;
  logic                 err_q;

  logic [NUM_REQ-1:0]   grant_oh;
  logic [IW-1:0]        grant_idx;
  logic                 any_grant;
  logic [NUM_REQ-1:0]   owner_oh_d;
  logic [31:0]          issue_rdata_d;
  logic                 issue_err_d;
  logic                 fifo_rd_ok_d;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_arbiter (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (grant_oh),
    .grant_idx  (grant_idx)
  );

  assign any_grant = |grant_oh;

  // One-hot ack pattern for the latched owner
  always_comb begin
    owner_oh_d = '0;
    owner_oh_d[owner_q] = 1'b1;
  end

  // Core strobes and register inputs, live only during ISSUE and gated by FIFO flags
  always_comb begin
    count_we     = 1'b0;
    config_we    = 1'b0;
    fifo_we      = 1'b0;
    fifo_re      = 1'b0;
    count_in     = '0;
    en_in        = 1'b0;
    dir_in       = 1'b0;
    ire_in       = 1'b0;
    fifo_data_in = '0;
    if (state_q == ST_ISSUE) begin
      if (we_q) begin
        case (addr_q)
          ADDR_COUNT: begin
            count_we = 1'b1;
            count_in = wdata_q;
          end
          ADDR_CONFIG: begin
            config_we = 1'b1;
            en_in     = wdata_q[CFG_EN_BIT];
            dir_in    = wdata_q[CFG_DIR_BIT];
            ire_in    = wdata_q[CFG_IRE_BIT];
          end
          ADDR_FIFO: begin
            if (!fifo_full) begin
              fifo_we      = 1'b1;
              fifo_data_in = wdata_q[7:0];
            end
          end
          default: ;
        endcase
      end else if (addr_q == ADDR_FIFO && !fifo_empty) begin
        fifo_re = 1'b1;
      end
    end
  end

  // Response data and refusal decision for the op sitting in ISSUE
  always_comb begin
    issue_rdata_d = '0;
    issue_err_d   = 1'b0;
    fifo_rd_ok_d  = 1'b0;
    if (we_q) begin
      case (addr_q)
        ADDR_FIFO:   issue_err_d = fifo_full;
        ADDR_STATUS: issue_err_d = 1'b1;
        default:     ;
      endcase
    end else begin
      case (addr_q)
        ADDR_COUNT:  issue_rdata_d = count_out;
        ADDR_CONFIG: issue_rdata_d = pack_config(en_out, dir_out, ire_out, lt_1k_out);
        ADDR_FIFO: begin
          issue_err_d  = fifo_empty;
          fifo_rd_ok_d = !fifo_empty;
        end
        default:     issue_rdata_d = pack_status(fifo_word_count, fifo_full, fifo_empty);
      endcase
    end
  end

  // Operation FSM: grant, issue, optional FIFO read wait, one-cycle response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IW'(NUM_REQ - 1);
      owner_q      <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      ack_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_grant) begin
            owner_q      <= grant_idx;
            last_grant_q <= grant_idx;
            we_q         <= req_we[grant_idx];
            addr_q       <= req_addr[2*int'(grant_idx) +: 2];
            wdata_q      <= req_wdata[32*int'(grant_idx) +: 32];
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (fifo_rd_ok_d) begin
            state_q <= ST_RDWAIT;
          end else begin
            ack_q   <= owner_oh_d;
            rdata_q <= issue_rdata_d;
            err_q   <= issue_err_d;
            state_q <= ST_RESP;
          end
        end
        ST_RDWAIT: begin
          ack_q   <= owner_oh_d;
          rdata_q <= {24'b0, fifo_data_out};
          state_q <= ST_RESP;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: doc/peripheral_native_register_arbiter.md
# peripheral_native_register_arbiter

Shares the peripheral core's native register port between `NUM_REQ` independent requesters, such as a host bus bridge and a DMA engine. Each requester issues single register operations (read or write to COUNT, CONFIG, FIFO or STATUS). The block grants one operation at a time in round-robin order and drives exactly one strobe per operation. It returns read data with a one-cycle acknowledge. It sits between the bus-side bridges and the counter/FIFO core, and is the only driver of the core's register inputs and strobes.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high.
- `req`  in  NUM_REQ  operation request per requester; held until its `ack`.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ×2  register select: 0 COUNT, 1 CONFIG, 2 FIFO, 3 STATUS.
- `req_wdata`  in  NUM_REQ×32  write data.
- `ack`  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- `rdata`  out  32  read data; valid only while an `ack` bit is high, otherwise 0.
- `err`  out  1  valid with `ack`: operation refused.
- `count_in`/`en_in`/`dir_in`/`ire_in`/`fifo_data_in`  out  32/1/1/1/8  core register inputs.
- `count_we`/`config_we`/`fifo_we`/`fifo_re`  out  1 each  core strobes.
- `count_out`/`en_out`/`dir_out`/`ire_out`/`lt_1k_out`  in  32/1/1/1/1  core state.
- `fifo_empty`/`fifo_full`/`fifo_word_count`/`fifo_data_out`  in  1/1/8/8  core FIFO state.

## Operation
**FSM states:** IDLE, ISSUE, RDWAIT, RESP.

**IDLE**
- If any `req` bit is set, pick the winner round-robin, searching from `last_grant+1`.
- Latch the winner's index, we, addr and wdata.
- Update `last_grant` and go to ISSUE.

**ISSUE** (exactly one cycle)
- COUNT write: `count_we`=1, `count_in`=wdata.
- CONFIG write: `config_we`=1, `en_in`/`dir_in`/`ire_in` = wdata[0]/[1]/[2].
- FIFO write: if `fifo_full`=0, `fifo_we`=1 and `fifo_data_in`=wdata[7:0]; otherwise no strobe and err=1.
- FIFO read: if `fifo_empty`=0, `fifo_re`=1 and go to RDWAIT; otherwise no strobe, err=1, go to RESP.
- COUNT, CONFIG or STATUS read: capture data this cycle.
  - COUNT reads `count_out`.
  - CONFIG reads {28'b0, lt_1k, ire, dir, en}.
  - STATUS reads {16'b0, fifo_word_count, 6'b0, fifo_full, fifo_empty}.
- STATUS write: no strobe, err=1.
- Every path except the successful FIFO read goes to RESP.

**RDWAIT**
- Capture {24'b0, fifo_data_out} and go to RESP.

**RESP**
- Assert `ack[owner]`=1 and drive `rdata`/`err`, then go to IDLE.
- Write acks return `rdata`=0.

**Other rules**
- Strobes are mutually exclusive and never high outside ISSUE.
- Outputs `count_in` etc. are 0 when no strobe is active.
- After the grant, the operation is latched. Changing or dropping `req` then has no effect on the in-flight op.
- Dropping `req` before grant is allowed; no op is issued.
- A requester may hold `req` high after `ack` to issue a new op. It is re-arbitrated in the following IDLE.

## Timing
- `req` seen in IDLE at cycle 0 → ISSUE cycle 1 → `ack` cycle 2.
- Successful FIFO read: ISSUE cycle 1, RDWAIT cycle 2, `ack` cycle 3.
- Peak throughput: one op per 3 cycles, or per 4 cycles for FIFO reads.
- FIFO read data latency: the core's `fifo_data_out` is valid the cycle after `fifo_re`.
- Reset values (asynchronous): state IDLE, `last_grant`=NUM_REQ-1 so requester 0 wins first; `ack`, `err`, `rdata`, all strobes and core inputs = 0.
- Reset mid-operation aborts the op with no `ack`. A strobe already issued in ISSUE is not undone.
- Simultaneous requests are fully resolved by rotation. No requester waits more than NUM_REQ grants.

## Structure
- Package `peripheral_native_arbiter_pkg` holds:
  - the state enum;
  - the address constants ADDR_COUNT/CONFIG/FIFO/STATUS;
  - the CONFIG bit positions (EN=0, DIR=1, IRE=2, LT1K=3);
  - the STATUS bit positions.
- Sub-module `rr_arbiter` (parameter N): inputs `req` and `last_grant`, outputs a one-hot grant plus its index. Purely combinational.

## Test plan
- Req0 writes COUNT 0x0000_1234 → `count_we` high only in cycle 1 with `count_in`=0x1234; `ack[0]` in cycle 2 with err=0, rdata=0.
- After reset, req0 and req1 both held high for 4 ops → grants 0,1,0,1, each `ack` 3 cycles apart.
- Req1 reads FIFO, `fifo_empty`=0, core returns 0xA5 → single `fifo_re` in cycle 1; `ack[1]` in cycle 3 with rdata=0x0000_00A5.
- FIFO write with `fifo_full`=1 → no `fifo_we`; `ack` with err=1. FIFO read with `fifo_empty`=1 → no `fifo_re`; `ack` in cycle 2 with err=1.
- CONFIG read with en=1, dir=0, ire=1, lt_1k=1 → rdata=0x0000_000D. STATUS write → no strobe, err=1.
- `reset` asserted during ISSUE → all outputs 0 immediately, no `ack`; after release, requester 0 wins the first grant.
